// File: rtl/wb_ext_slave_mem.sv
// wb_ext_slave_mem
//   Wishbone B3 responder backing one 32-bit wb_ext lane with an on-chip,
//   word-addressed SRAM window. Handles classic cycles and registered-feedback
//   incrementing bursts (linear, wrap-4/8/16). Out-of-window beats are ended
//   with err_o, or with ack_o, read data 0 and no write when ERR_ON_OOR=0.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   wb_adr_i        byte address (bits [1:0] ignored)
//   wb_dat_i        write data
//   wb_sel_i        byte enables
//   wb_we_i         write enable
//   wb_cyc_i        bus cycle valid
//   wb_stb_i        strobe
//   wb_cti_i        cycle type (000 classic, 010 incrementing, 111 end)
//   wb_bte_i        burst type (00 linear, 01/10/11 wrap-4/8/16)
//   wb_cab_i        legacy, ignored
//   wb_ack_o        normal termination (registered)
//   wb_err_o        error termination (registered)
//   wb_rty_o        retry, always 0
//   wb_dat_o        read data, meaningful while wb_ack_o=1 (registered)
module wb_ext_slave_mem #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned MEM_SIZE_BYTES = 65536,
    parameter int unsigned WAIT_STATES    = 0,
    parameter bit          ERR_ON_OOR     = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    input  logic        wb_cab_i,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    output logic [31:0] wb_dat_o
);

    localparam int unsigned DEPTH = MEM_SIZE_BYTES / 4;
    localparam int unsigned AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP, BURST} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [2:0]  cti_q, cti_d;
    logic [1:0]  bte_q, bte_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] dat_q, dat_d;

    logic [31:0] mem [DEPTH];

    logic          cs;
    logic          resp_en;
    logic [31:0]   resp_addr;
    logic          wr_en;
    logic [29:0]   wrd, wmask;
    logic [31:0]   nxt_addr;
    logic [31:0]   cur_off, rsp_off;
    logic          cur_ok, rsp_ok;
    logic [AW-1:0] cur_idx, rsp_idx;
    logic [31:0]   rdata;
    logic          unused_cab;

    assign cs         = wb_cyc_i & wb_stb_i;
    assign unused_cab = wb_cab_i;

    // Next burst address: bits under wmask step modulo the wrap length,
    // the rest are held; linear bursts use an all-ones mask (plain +4).
    always_comb begin
        case (bte_q)
            2'b01:   wmask = 30'd3;
            2'b10:   wmask = 30'd7;
            2'b11:   wmask = 30'd15;
            default: wmask = '1;
        endcase
        wrd      = addr_q[31:2];
        nxt_addr = {(wrd & ~wmask) | ((wrd + 30'd1) & wmask), 2'b00};
    end

    assign cur_off = addr_q - BASE_ADDR;
    assign cur_ok  = (addr_q >= BASE_ADDR) && (cur_off < MEM_SIZE_BYTES);
    assign cur_idx = cur_off[AW+1:2];
    assign rsp_off = resp_addr - BASE_ADDR;
    assign rsp_ok  = (resp_addr >= BASE_ADDR) && (rsp_off < MEM_SIZE_BYTES);
    assign rsp_idx = rsp_off[AW+1:2];

    // Write-first: a beat written at this edge is visible to the read
    // registered at the same edge.
    always_comb begin
        rdata = mem[rsp_idx];
        if (wr_en && (rsp_idx == cur_idx)) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wb_sel_i[b]) rdata[8*b +: 8] = wb_dat_i[8*b +: 8];
            end
        end
    end

    // ack_q/err_q mark the beat presented in the current cycle; that beat
    // completes at the next edge only if the master still holds cyc&stb.
    // resp_en/resp_addr select the beat whose response is registered now.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        we_d      = we_q;
        cti_d     = cti_q;
        bte_d     = bte_q;
        cnt_d     = cnt_q;
        resp_en   = 1'b0;
        resp_addr = addr_q;
        wr_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs) begin
                    addr_d    = wb_adr_i;
                    we_d      = wb_we_i;
                    cti_d     = wb_cti_i;
                    bte_d     = wb_bte_i;
                    resp_addr = wb_adr_i;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                        resp_en = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 3'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = RESP;
                    resp_en = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (cs && ack_q) begin
                    wr_en = we_q & cur_ok;
                    if (cti_q == 3'b010 && wb_cti_i != 3'b111 && wb_cti_i != 3'b000) begin
                        state_d   = BURST;
                        addr_d    = nxt_addr;
                        resp_addr = nxt_addr;
                        resp_en   = 1'b1;
                    end
                end
            end
            BURST: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else if ((ack_q || err_q) && wb_stb_i) begin
                    wr_en = ack_q & we_q & cur_ok;
                    if (err_q || wb_cti_i == 3'b111 || wb_cti_i == 3'b000) begin
                        state_d = IDLE;
                    end else begin
                        addr_d    = nxt_addr;
                        resp_addr = nxt_addr;
                        resp_en   = 1'b1;
                    end
                end else begin
                    // Stall or resume: address frozen, respond once stb is back.
                    resp_en = wb_stb_i;
                end
            end
            default: state_d = IDLE;
        endcase

        ack_d = resp_en & (rsp_ok | ~ERR_ON_OOR);
        err_d = resp_en & ~rsp_ok & ERR_ON_OOR;
        dat_d = (resp_en && rsp_ok) ? rdata : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            cti_q   <= '0;
            bte_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            cti_q   <= cti_d;
            bte_q   <= bte_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wb_sel_i[b]) mem[cur_idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
            end
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_rty_o = 1'b0;
    assign wb_dat_o = dat_q;

endmodule
